int_to_online_serializer: RTL and testbench
===========================================

INT_TO_ONLINE_SERIALIZER -- requirements
Module: int_to_online_serializer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CH, 2, number of parallel channels sharing one frame.
- INT_WIDTH, 8, magnitude width; each channel word is INT_WIDTH+1 bits, two's complement.
- OFFSET_WIDTH, 4, width of the leading-zero-digit offset.
- ENCODING_MODE, "signed-digit", digit encoding: "signed-digit" or "borrow-save".
- ADJUST_ENABLE, 0, 1 enables common normalization across channels.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Reset is i_rstn, asynchronous, active-low; clock is i_clk.
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_s_valid  in  1  input frame valid.
- o_s_ready  out  1  input frame accepted when high with i_s_valid.
- i_s_data  in  NUM_CH*(INT_WIDTH+1)  channel words; channel k occupies bits [k*(INT_WIDTH+1) +: INT_WIDTH+1].
- i_s_offset  in  OFFSET_WIDTH  number of zero digits emitted before the magnitude digits.
- o_m_digit  out  2*NUM_CH  one 2-bit digit per channel; channel k occupies [2k+:2].
- o_m_valid  out  1  digit valid.
- i_m_ready  in  1  downstream accepts the digit.
- o_m_last  out  1  final digit of the frame.
- o_norm_shift  out  clog2(INT_WIDTH)  applied normalization shift, valid from the first digit through o_m_last.

Function
REQ-003 Encoding SHALL be: signed-digit +1=2'b10, -1=2'b01, 0=2'b00; borrow-save +1=2'b01, -1=2'b11, 0=2'b00.
REQ-004 The FSM SHALL have states IDLE, ALIGN and EMIT; o_s_ready SHALL be 1 only in IDLE.
REQ-005 On acceptance the block SHALL register, per channel, sign = MSB and magnitude = |value| on INT_WIDTH bits.
- The most-negative input -2^INT_WIDTH SHALL saturate to magnitude 2^INT_WIDTH-1.
- The offset SHALL be latched at the same time.
REQ-006 With ADJUST_ENABLE=0, acceptance SHALL transition IDLE->EMIT, and o_m_valid SHALL be high the next cycle; o_norm_shift SHALL be 0.
REQ-007 With ADJUST_ENABLE=1, acceptance SHALL transition IDLE->ALIGN.
- Each ALIGN cycle SHALL left-shift all magnitudes by 1 and increment the shift count.
- ALIGN SHALL exit to EMIT when any magnitude has MSB=1, when all magnitudes are 0, or when the shift count reaches INT_WIDTH-1. Exit evaluation occurs before the shift, so 0 ALIGN-shift cycles are possible.
- The shift count SHALL be reported on o_norm_shift.
REQ-008 EMIT SHALL present first offset digits of 00 on all channels, then INT_WIDTH magnitude digits MSB first.
- Each magnitude digit is 0 if the bit is 0, +1 if the bit is 1 and sign=0, -1 if the bit is 1 and sign=1.
- Frame length SHALL be offset+INT_WIDTH digits.
REQ-009 A digit SHALL advance only on o_m_valid & i_m_ready.
- o_m_digit, o_m_last and o_norm_shift SHALL be held stable while o_m_valid=1 and i_m_ready=0.
REQ-010 o_m_last SHALL be 1 only on the final digit of the frame. Acceptance of that digit SHALL return the FSM to IDLE, with o_m_valid=0 the next cycle.
REQ-011 An offset of 0 SHALL emit no zero-prefix. The offset counter SHALL not wrap: the maximum offset 2^OFFSET_WIDTH-1 yields exactly that many zero digits.
REQ-012 i_s_valid while not in IDLE SHALL be ignored (no acceptance).
REQ-013 An unsupported ENCODING_MODE SHALL output 2'b00 for every digit.

Reset
REQ-014 Asserting i_rstn=0 SHALL immediately force the following, regardless of state, including mid-frame or mid-ALIGN:
- state=IDLE, o_s_ready=1 after reset release, o_m_valid=0, o_m_last=0, o_m_digit=0, o_norm_shift=0;
- all internal magnitude, sign and counter registers = 0.

Verification (INT_WIDTH=4, NUM_CH=2, signed-digit)
- ADJUST=0, offset=0, ch0=3, ch1=-5 -> ch0 digits 00,00,10,10; ch1 digits 00,01,00,01; o_m_last on the 4th digit; o_norm_shift=0.
- ADJUST=1, same data -> one ALIGN cycle; ch0 00,10,10,00; ch1 01,00,01,00; o_norm_shift=1.
- ADJUST=0, offset=2, ch0=1, ch1=0 -> 6 digits: ch0 00,00,00,00,00,10; ch1 all 00; o_m_last on the 6th digit.
- ch0=-16, ch1=0 -> saturation; ch0 01,01,01,01.
- i_m_ready held low 3 cycles mid-frame -> digit and o_m_last stable, no digit lost or duplicated; o_s_ready stays 0.
- i_rstn pulsed during the 2nd digit -> o_m_valid=0 immediately, o_s_ready=1 after release, and the next frame is emitted correctly from its first digit.

Source files
------------

// File: rtl/int_to_online_serializer.sv
// Converts a frame of two's-complement channel words into a stream of 2-bit online digits
// (MSB first, optional zero prefix), with optional common left-normalization across channels.
module int_to_online_serializer #(
  parameter int    NUM_CH        = 2,
  parameter int    INT_WIDTH     = 8,
  parameter int    OFFSET_WIDTH  = 4,
  parameter string ENCODING_MODE = "signed-digit",
  parameter int    ADJUST_ENABLE = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rstn,
  input  logic                            i_s_valid,
  output logic                            o_s_ready,
  input  logic [NUM_CH*(INT_WIDTH+1)-1:0] i_s_data,
  input  logic [OFFSET_WIDTH-1:0]         i_s_offset,
  output logic [2*NUM_CH-1:0]             o_m_digit,
  output logic                            o_m_valid,
  input  logic                            i_m_ready,
  output logic                            o_m_last,
  output logic [((INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1)-1:0] o_norm_shift
);

  localparam int WW      = INT_WIDTH + 1;
  localparam int SHW     = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1;
  localparam int ENC_SD  = 0;
  localparam int ENC_BS  = 1;
  localparam int ENC_SEL = (ENCODING_MODE == "signed-digit") ? ENC_SD :
                           ((ENCODING_MODE == "borrow-save") ? ENC_BS : 2);
  localparam logic [SHW-1:0] LAST_IDX = SHW'(INT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, ALIGN = 2'b01, EMIT = 2'b10} state_t;
  typedef logic [NUM_CH-1:0][INT_WIDTH-1:0] mag_t;

  function automatic logic [1:0] enc_digit(input logic b, input logic s);
    logic [1:0] d;
    d = 2'b00;
    if (b) begin
      case (ENC_SEL)
        ENC_SD:  d = s ? 2'b01 : 2'b10;
        ENC_BS:  d = s ? 2'b11 : 2'b01;
        default: d = 2'b00;
      endcase
    end else begin
      d = 2'b00;
    end
    return d;
  endfunction

  // The zero prefix masks every channel; afterwards each channel shows its current MSB.
  function automatic logic [2*NUM_CH-1:0] frame_digit(input mag_t m, input logic [NUM_CH-1:0] s,
                                                      input logic [OFFSET_WIDTH-1:0] off);
    logic [2*NUM_CH-1:0] d;
    d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (off == '0) d[2*k +: 2] = enc_digit(m[k][INT_WIDTH-1], s[k]);
      else           d[2*k +: 2] = 2'b00;
    end
    return d;
  endfunction

  // -2^INT_WIDTH has no INT_WIDTH-bit magnitude, so it clamps to all ones.
  function automatic logic [INT_WIDTH-1:0] abs_sat(input logic [WW-1:0] v);
    logic [WW-1:0]        neg;
    logic [INT_WIDTH-1:0] m;
    neg = ~v + 1'b1;
    if (!v[WW-1])            m = v[INT_WIDTH-1:0];
    else if (neg[INT_WIDTH]) m = '1;
    else                     m = neg[INT_WIDTH-1:0];
    return m;
  endfunction

  state_t                   state_r, state_nxt_s;
  mag_t                     mag_r, mag_nxt_s;
  logic [NUM_CH-1:0]        sign_r, sign_nxt_s;
  logic [OFFSET_WIDTH-1:0]  off_r, off_nxt_s;
  logic [SHW-1:0]           bit_r, bit_nxt_s;
  logic [SHW-1:0]           shift_r, shift_nxt_s;
  logic                     any_msb_s, all_zero_s;
  logic                     valid_r, last_r, ready_r;
  logic [2*NUM_CH-1:0]      digit_r;
  logic                     valid_nxt_s, last_nxt_s, ready_nxt_s;
  logic [2*NUM_CH-1:0]      digit_nxt_s;

  // Normalization exit conditions, evaluated on the unshifted magnitudes.
  always_comb begin
    any_msb_s  = 1'b0;
    all_zero_s = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      any_msb_s  = any_msb_s | mag_r[k][INT_WIDTH-1];
      all_zero_s = all_zero_s & (mag_r[k] == '0);
    end
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_nxt_s = state_r;
    mag_nxt_s   = mag_r;
    sign_nxt_s  = sign_r;
    off_nxt_s   = off_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    case (state_r)
      IDLE: begin
        if (i_s_valid) begin
          for (int k = 0; k < NUM_CH; k++) begin
            sign_nxt_s[k] = i_s_data[k*WW + INT_WIDTH];
            mag_nxt_s[k]  = abs_sat(i_s_data[k*WW +: WW]);
          end
          off_nxt_s   = i_s_offset;
          bit_nxt_s   = '0;
          shift_nxt_s = '0;
          state_nxt_s = (ADJUST_ENABLE != 0) ? ALIGN : EMIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ALIGN: begin
        if (any_msb_s || all_zero_s || (shift_r == LAST_IDX)) begin
          state_nxt_s = EMIT;
        end else begin
          for (int k = 0; k < NUM_CH; k++) mag_nxt_s[k] = mag_r[k] << 1;
          shift_nxt_s = shift_r + 1'b1;
        end
      end
      EMIT: begin
        if (valid_r && i_m_ready) begin
          if (last_r) begin
            state_nxt_s = IDLE;
          end else if (off_r != '0) begin
            off_nxt_s = off_r - 1'b1;
          end else begin
            for (int k = 0; k < NUM_CH; k++) mag_nxt_s[k] = mag_r[k] << 1;
            bit_nxt_s = bit_r + 1'b1;
          end
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs are derived from the next state so that they leave the block registered.
  always_comb begin
    valid_nxt_s = (state_nxt_s == EMIT);
    ready_nxt_s = (state_nxt_s == IDLE);
    if (valid_nxt_s) begin
      digit_nxt_s = frame_digit(mag_nxt_s, sign_nxt_s, off_nxt_s);
      last_nxt_s  = (off_nxt_s == '0) && (bit_nxt_s == LAST_IDX);
    end else begin
      digit_nxt_s = '0;
      last_nxt_s  = 1'b0;
    end
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= IDLE;
      mag_r   <= '0;
      sign_r  <= '0;
      off_r   <= '0;
      bit_r   <= '0;
      shift_r <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      digit_r <= '0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      mag_r   <= mag_nxt_s;
      sign_r  <= sign_nxt_s;
      off_r   <= off_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
      digit_r <= digit_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  assign o_s_ready    = ready_r;
  assign o_m_valid    = valid_r;
  assign o_m_last     = last_r;
  assign o_m_digit    = digit_r;
  assign o_norm_shift = shift_r;

endmodule

// File: tb/tb_int_to_online_serializer.sv
// Directed bench: three instances (signed-digit, signed-digit with normalization, borrow-save)
// share one input stream; each frame's digit stream is captured and compared with hand-computed vectors.
module tb_int_to_online_serializer;
  localparam int NCH = 2;
  localparam int IW  = 4;
  localparam int OW  = 4;
  localparam int DW  = NCH * (IW + 1);
  localparam int SW  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [OW-1:0] s_offset = '0;
  logic          s_ready[3];
  logic [2*NCH-1:0] m_digit[3];
  logic          m_valid[3];
  logic          m_last[3];
  logic [SW-1:0] norm_shift[3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_to_online_serializer #(.NUM_CH(NCH), .INT_WIDTH(IW), .OFFSET_WIDTH(OW),
    .ENCODING_MODE("signed-digit"), .ADJUST_ENABLE(0)) dut_sd (
    .i_clk(clk), .i_rstn(rstn), .i_s_valid(s_valid), .o_s_ready(s_ready[0]),
    .i_s_data(s_data), .i_s_offset(s_offset), .o_m_digit(m_digit[0]), .o_m_valid(m_valid[0]),
    .i_m_ready(m_ready), .o_m_last(m_last[0]), .o_norm_shift(norm_shift[0]));

  int_to_online_serializer #(.NUM_CH(NCH), .INT_WIDTH(IW), .OFFSET_WIDTH(OW),
    .ENCODING_MODE("signed-digit"), .ADJUST_ENABLE(1)) dut_adj (
    .i_clk(clk), .i_rstn(rstn), .i_s_valid(s_valid), .o_s_ready(s_ready[1]),
    .i_s_data(s_data), .i_s_offset(s_offset), .o_m_digit(m_digit[1]), .o_m_valid(m_valid[1]),
    .i_m_ready(m_ready), .o_m_last(m_last[1]), .o_norm_shift(norm_shift[1]));

  int_to_online_serializer #(.NUM_CH(NCH), .INT_WIDTH(IW), .OFFSET_WIDTH(OW),
    .ENCODING_MODE("borrow-save"), .ADJUST_ENABLE(0)) dut_bs (
    .i_clk(clk), .i_rstn(rstn), .i_s_valid(s_valid), .o_s_ready(s_ready[2]),
    .i_s_data(s_data), .i_s_offset(s_offset), .o_m_digit(m_digit[2]), .o_m_valid(m_valid[2]),
    .i_m_ready(m_ready), .o_m_last(m_last[2]), .o_norm_shift(norm_shift[2]));

  // Digit j of a frame sits in seq[4*j +: 4] as {ch1, ch0}.
  typedef struct {
    logic [4:0]  c0;
    logic [4:0]  c1;
    logic [3:0]  off;
    int          len;
    logic [79:0] seq;
    logic [79:0] seq_adj;
    logic [1:0]  shift_adj;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [79:0] to_bs(input logic [79:0] s);
    logic [79:0] r;
    r = '0;
    for (int j = 0; j < 40; j++) begin
      case (s[2*j +: 2])
        2'b10:   r[2*j +: 2] = 2'b01;
        2'b01:   r[2*j +: 2] = 2'b11;
        default: r[2*j +: 2] = 2'b00;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: always ready; 1: random back-pressure; 2: ready low for three cycles mid-frame.
  task automatic run_frame(input vec_t v, input int mode, input string tag);
    logic [79:0]      cap[3];
    int               cnt[3];
    bit               done[3];
    logic [1:0]       shift_cap[3];
    bit               held[3];
    logic [2*NCH-1:0] held_d[3];
    logic             held_l[3];
    logic [79:0]      exp_seq[3];
    logic [1:0]       exp_shift[3];
    int               w;
    bit               all_done;
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0; cnt[i] = 0; done[i] = 1'b0; shift_cap[i] = 2'b00;
      held[i] = 1'b0; held_d[i] = '0; held_l[i] = 1'b0;
    end
    exp_seq[0] = v.seq;  exp_seq[1] = v.seq_adj;  exp_seq[2] = to_bs(v.seq);
    exp_shift[0] = 2'd0; exp_shift[1] = v.shift_adj; exp_shift[2] = 2'd0;
    w = 0;
    while (!(s_ready[0] && s_ready[1] && s_ready[2]) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, " idle_wait"}, 80'(w < 50), 80'd1);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = {v.c1, v.c0}; s_offset = v.off; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = '1; s_offset = '1;
    all_done = 1'b0;
    for (int cyc = 0; cyc < 200 && !all_done; cyc++) begin
      @(negedge clk);
      case (mode)
        1:       m_ready = ($urandom_range(0, 3) != 0);
        2:       m_ready = !(cyc >= 2 && cyc < 5);
        default: m_ready = 1'b1;
      endcase
      for (int i = 0; i < 3; i++) begin
        if (held[i]) begin
          check({tag, " stall_valid"}, 80'(m_valid[i]), 80'd1);
          check({tag, " stall_digit"}, 80'(m_digit[i]), 80'(held_d[i]));
          check({tag, " stall_last"}, 80'(m_last[i]), 80'(held_l[i]));
          held[i] = 1'b0;
        end
        if (m_valid[i] && !done[i]) begin
          check({tag, " busy_ready"}, 80'(s_ready[i]), 80'd0);
          if (m_ready) begin
            if (cnt[i] < 20) cap[i][4*cnt[i] +: 4] = m_digit[i];
            cnt[i]++;
            if (m_last[i]) begin
              done[i] = 1'b1;
              shift_cap[i] = norm_shift[i];
            end
          end else begin
            held[i] = 1'b1; held_d[i] = m_digit[i]; held_l[i] = m_last[i];
          end
        end
      end
      all_done = done[0] && done[1] && done[2];
      // Junk frames offered while every instance is busy must be ignored.
      s_valid = (!s_ready[0] && !s_ready[1] && !s_ready[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    s_valid = 1'b0;
    check({tag, " frame_done"}, 80'(all_done), 80'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s dut%0d digits", tag, i), cap[i], exp_seq[i]);
      check($sformatf("%s dut%0d length", tag, i), 80'(cnt[i]), 80'(v.len));
      check($sformatf("%s dut%0d shift", tag, i), 80'(shift_cap[i]), 80'(exp_shift[i]));
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("%s dut%0d valid_after", tag, i), 80'(m_valid[i]), 80'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'b00011, 5'b11011, 4'd0,  4,  80'h6240,                   80'h0624,                   2'd1};
    vecs[1] = '{5'b00001, 5'b00000, 4'd2,  6,  80'h0020_0000,              80'h0000_0200,              2'd3};
    vecs[2] = '{5'b10000, 5'b00000, 4'd0,  4,  80'h1111,                   80'h1111,                   2'd0};
    vecs[3] = '{5'b00000, 5'b00000, 4'd1,  5,  80'h0,                      80'h0,                      2'd0};
    vecs[4] = '{5'b01111, 5'b11111, 4'd0,  4,  80'h6222,                   80'h6222,                   2'd0};
    vecs[5] = '{5'b00010, 5'b11101, 4'd3,  7,  80'h0460_0000,              80'h0004_6000,              2'd2};
    vecs[6] = '{5'b11000, 5'b00111, 4'd15, 19, 80'h0888_1000_0000_0000_0000, 80'h0888_1000_0000_0000_0000, 2'd0};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset dut%0d valid", i), 80'(m_valid[i]), 80'd0);
      check($sformatf("reset dut%0d last", i), 80'(m_last[i]), 80'd0);
      check($sformatf("reset dut%0d digit", i), 80'(m_digit[i]), 80'd0);
      check($sformatf("reset dut%0d shift", i), 80'(norm_shift[i]), 80'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("release dut%0d ready", i), 80'(s_ready[i]), 80'd1);

    for (int t = 0; t < 7; t++) run_frame(vecs[t], (t == 4) ? 1 : 0, $sformatf("vec%0d", t));
    run_frame(vecs[0], 2, "stall3");
    run_frame(vecs[5], 1, "rand_bp");

    // Reset pulsed while the second digit is on the output.
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = {vecs[5].c1, vecs[5].c0}; s_offset = 4'd0; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset pre_valid", 80'(m_valid[0]), 80'd1);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset dut%0d valid", i), 80'(m_valid[i]), 80'd0);
      check($sformatf("midreset dut%0d last", i), 80'(m_last[i]), 80'd0);
      check($sformatf("midreset dut%0d digit", i), 80'(m_digit[i]), 80'd0);
      check($sformatf("midreset dut%0d shift", i), 80'(norm_shift[i]), 80'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("midreset dut%0d ready", i), 80'(s_ready[i]), 80'd1);
    run_frame(vecs[0], 0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
